nap_countdown_ctrl: RTL and testbench
=====================================

NAP_COUNTDOWN_CTRL -- requirements
Module: nap_countdown_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 500000; clock cycles per 1 s countdown tick, minimum 2.
REQ-002 SHALL have parameter SNOOZE_MIN, default 5; snooze duration in minutes, range 1..59.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3; maximum snoozes per nap, range 1..15.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 load  in  1  pulse; capture set_time.
REQ-007 set_time  in  24  BCD HH:MM:SS, [23:20] hour10 down to [3:0] sec1.
REQ-008 start  in  1  pulse; begin or resume countdown.
REQ-009 pause  in  1  pulse; hold countdown.
REQ-010 cancel  in  1  pulse; abort to idle.
REQ-011 ack  in  1  pulse; dismiss alarm.
REQ-012 snooze  in  1  pulse; re-arm from alarm.
REQ-013 remaining  out  24  current BCD time left.
REQ-014 state  out  3  IDLE=0, ARMED=1, RUN=2, PAUSE=3, ALARM=4.
REQ-015 tick  out  1  one-cycle pulse per decrement.
REQ-016 done  out  1  one-cycle pulse on entry to ALARM.
REQ-017 alarm  out  1  high while state is ALARM.
REQ-018 error  out  1  sticky invalid-load flag.
REQ-019 snooze_cnt  out  4  snoozes used in current nap.

Function
REQ-020 Input priority per cycle SHALL be cancel > ack > snooze > pause > start > load; only the highest asserted input is acted on.
REQ-021 Valid time: every digit <=9, sec10 <=5, min10 <=5, hour <=23. Any other set_time value is invalid.
REQ-022 IDLE: valid load -> ARMED, remaining=set_time, error cleared, snooze_cnt=0. Invalid load -> stay IDLE, remaining unchanged, error=1.
REQ-023 ARMED: start -> RUN, prescaler cleared. A valid load while ARMED reloads remaining. An invalid load sets error and leaves state and remaining unchanged.
REQ-024 RUN: prescaler counts 0..TICK_CYCLES-1. At the terminal count, tick=1 and remaining decrements by 1 s with BCD borrow: sec1->sec10 (0..5)->min1->min10 (0..5)->hour.
REQ-025 RUN: the decrement that reaches 00:00:00 SHALL move to ALARM in the same edge, with done=1 for that one cycle.
REQ-026 A start issued in ARMED with remaining=00:00:00 SHALL enter ALARM on the next edge (done pulse) without entering RUN.
REQ-027 pause in RUN -> PAUSE; the prescaler value is held. start in PAUSE -> RUN, resuming from the held prescaler. load is ignored in RUN and PAUSE.
REQ-028 cancel in any state -> IDLE, remaining=0, snooze_cnt=0; error unchanged.
REQ-029 ALARM: ack -> IDLE with remaining=0. snooze is handled per Configuration. Other inputs are ignored.
REQ-030 tick SHALL be asserted only in RUN; no tick in any other state.
REQ-031 Outputs SHALL be registered; state change is visible 1 cycle after the input pulse.

Reset
REQ-032 On reset=0 at a clock edge: state=IDLE, remaining=0, prescaler=0, tick=0, done=0, alarm=0, error=0, snooze_cnt=0.
REQ-033 Reset SHALL override every input, including a reset asserted mid-countdown or during ALARM.

Configuration
REQ-034 Macro NAP_SNOOZE_EN enables the snooze feature.
- When defined: snooze in ALARM with snooze_cnt<MAX_SNOOZE -> RUN, remaining=00:SNOOZE_MIN:00, prescaler cleared, snooze_cnt+1.
- When defined: snooze with snooze_cnt=MAX_SNOOZE is ignored; the block stays in ALARM.
- When undefined: the snooze input is ignored, snooze_cnt is tied to 0, and no snooze logic is synthesised.

Verification (TICK_CYCLES=4, SNOOZE_MIN=1, MAX_SNOOZE=2)
REQ-035 load 0x000003, start -> tick every 4 cycles; remaining 02, 01, 00; done pulse with the third tick; alarm=1; ack -> state=0, alarm=0.
REQ-036 load 0x010000, start, one tick -> remaining=0x005959; load 0x235960 -> error=1, state and remaining unchanged.
REQ-037 In RUN, pause for 20 cycles -> no tick, remaining constant; start -> next tick after the remaining prescaler cycles.
REQ-038 (NAP_SNOOZE_EN) In ALARM, snooze -> remaining=0x000100, snooze_cnt=1; after two snoozes a third snooze -> stays ALARM, snooze_cnt=2.
REQ-039 cancel and ack asserted together in ALARM -> IDLE, remaining=0; reset=0 mid-RUN -> all outputs at their reset values on the next edge.
REQ-040 load 0x000000, start -> ALARM with done pulse and tick never asserted.

Source files
------------

// File: rtl/nap_countdown_ctrl.sv
// nap_countdown_ctrl: BCD HH:MM:SS nap countdown with pause, alarm and ack.
// Snooze support is built only when NAP_SNOOZE_EN is defined.
module nap_countdown_ctrl #(
  parameter int TICK_CYCLES = 500000,
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] set_time,
  input  logic        start,
  input  logic        pause,
  input  logic        cancel,
  input  logic        ack,
  input  logic        snooze,
  output logic [23:0] remaining,
  output logic [2:0]  state,
  output logic        tick,
  output logic        done,
  output logic        alarm,
  output logic        error,
  output logic [3:0]  snooze_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, RUN = 3'd2, PAUSE = 3'd3, ALARM = 3'd4} state_t;
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_END = PW'(TICK_CYCLES - 1);
  localparam logic [23:0] SNZ_T = {8'h00, 4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};
`ifdef NAP_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [23:0] rem_q, rem_d, rem_dec;
  logic [PW-1:0] pre_q, pre_d;
  logic tick_d, done_d, err_q, err_d, vld, snz_go;
  logic hi_ak, hi_sn, hi_pa, hi_st, hi_ld;
  logic [3:0] cnt_q;
  function automatic logic valid_time(input logic [23:0] t);
    return t[3:0] <= 4'd9 && t[7:4] <= 4'd5 && t[11:8] <= 4'd9 && t[15:12] <= 4'd5 &&
           t[19:16] <= 4'd9 && (t[23:20] < 4'd2 || (t[23:20] == 4'd2 && t[19:16] <= 4'd3));
  endfunction
  // Each digit borrows from the next one up; callers never pass 00:00:00.
  function automatic logic [23:0] dec_bcd(input logic [23:0] t);
    logic [23:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8] = 4'd9;
          if (t[15:12] != 4'd0) r[15:12] = t[15:12] - 4'd1;
          else begin
            r[15:12] = 4'd5;
            if (t[19:16] != 4'd0) r[19:16] = t[19:16] - 4'd1;
            else begin
              r[19:16] = 4'd9;
              r[23:20] = t[23:20] - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction
  assign hi_ak = ack & ~cancel;
  assign hi_sn = snooze & ~cancel & ~ack;
  assign hi_pa = pause & ~(cancel | ack | snooze);
  assign hi_st = start & ~(cancel | ack | snooze | pause);
  assign hi_ld = load & ~(cancel | ack | snooze | pause | start);
  assign vld = valid_time(set_time);
  assign rem_dec = dec_bcd(rem_q);
  assign snz_go = SNZ_EN && state_q == ALARM && hi_sn && cnt_q != 4'(MAX_SNOOZE);
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    pre_d = pre_q;
    tick_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q;
    if (cancel) begin
      state_d = IDLE;
      rem_d = '0;
    end else begin
      case (state_q)
        IDLE: if (hi_ld) begin
          state_d = vld ? ARMED : IDLE;
          rem_d = vld ? set_time : rem_q;
          err_d = !vld;
        end
        ARMED: if (hi_st) begin
          state_d = rem_q == '0 ? ALARM : RUN;
          done_d = rem_q == '0;
          pre_d = '0;
        end else if (hi_ld) begin
          rem_d = vld ? set_time : rem_q;
          err_d = err_q | !vld;
        end
        RUN: if (hi_pa) state_d = PAUSE;
        else if (pre_q == PRE_END) begin
          pre_d = '0;
          tick_d = 1'b1;
          rem_d = rem_dec;
          state_d = rem_dec == '0 ? ALARM : RUN;
          done_d = rem_dec == '0;
        end else pre_d = pre_q + 1'b1;
        PAUSE: if (hi_st) state_d = RUN;
        ALARM: if (hi_ak) begin
          state_d = IDLE;
          rem_d = '0;
        end else if (snz_go) begin
          state_d = RUN;
          rem_d = SNZ_T;
          pre_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      pre_q <= '0;
      tick <= 1'b0;
      done <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      pre_q <= pre_d;
      tick <= tick_d;
      done <= done_d;
      err_q <= err_d;
    end
  end
`ifdef NAP_SNOOZE_EN
  always_ff @(posedge clock) begin
    if (!reset || cancel || (state_q == IDLE && hi_ld && vld)) cnt_q <= '0;
    else if (snz_go) cnt_q <= cnt_q + 4'd1;
  end
`else
  assign cnt_q = '0;
`endif
  assign remaining = rem_q;
  assign state = state_q;
  assign alarm = state_q == ALARM;
  assign error = err_q;
  assign snooze_cnt = cnt_q;
endmodule

// File: tb/tb_nap_countdown_ctrl.sv
// tb_nap_countdown_ctrl: vector table plus scoreboard queue for nap_countdown_ctrl
// with TICK_CYCLES=4, SNOOZE_MIN=1, MAX_SNOOZE=2.
module tb_nap_countdown_ctrl;
  localparam logic [5:0] LD = 6'b100000, ST = 6'b010000, PA = 6'b001000, CA = 6'b000100, AK = 6'b000010, SN = 6'b000001;
  localparam logic [2:0] S_I = 3'd0, S_A = 3'd1, S_R = 3'd2, S_P = 3'd3, S_L = 3'd4;
  typedef struct {
    logic rs;
    logic [5:0] in;
    logic [23:0] t;
    logic [2:0] st;
    logic [23:0] rem;
    logic tk;
    logic dn;
    logic er;
    logic [3:0] sc;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  logic clock = 1'b0, reset = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic cancel = 1'b0, ack = 1'b0, snooze = 1'b0;
  logic [23:0] set_time = '0;
  logic [23:0] remaining;
  logic [2:0] state;
  logic tick, done, alarm, error;
  logic [3:0] snooze_cnt;
  int tests = 0, fails = 0;
  nap_countdown_ctrl #(.TICK_CYCLES(4), .SNOOZE_MIN(1), .MAX_SNOOZE(2)) dut (
    .clock(clock), .reset(reset), .load(load), .set_time(set_time), .start(start),
    .pause(pause), .cancel(cancel), .ack(ack), .snooze(snooze), .remaining(remaining),
    .state(state), .tick(tick), .done(done), .alarm(alarm), .error(error), .snooze_cnt(snooze_cnt)
  );
  always #5 clock = ~clock;
  function automatic logic [23:0] to_bcd(input int s);
    int h, m, c;
    h = s / 3600;
    m = (s / 60) % 60;
    c = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction
  function automatic void add(input logic [5:0] in, input logic [23:0] t, input logic [2:0] st,
                              input logic [23:0] rem, input logic tk = 1'b0, input logic dn = 1'b0,
                              input logic er = 1'b0, input logic [3:0] sc = 4'd0, input logic rs = 1'b0);
    vec_t v;
    v.rs = rs; v.in = in; v.t = t; v.st = st; v.rem = rem;
    v.tk = tk; v.dn = dn; v.er = er; v.sc = sc;
    vecs.push_back(v);
  endfunction
  task automatic chk(input vec_t e, input int n);
    logic [34:0] got, exp;
    got = {state, remaining, tick, done, alarm, error, snooze_cnt};
    exp = {e.st, e.rem, e.tk, e.dn, e.st == S_L, e.er, e.sc};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL vec%0d: got st=%0d rem=%h tick=%b done=%b alarm=%b err=%b sc=%0d, exp st=%0d rem=%h tick=%b done=%b alarm=%b err=%b sc=%0d",
               n, state, remaining, tick, done, alarm, error, snooze_cnt,
               e.st, e.rem, e.tk, e.dn, e.st == S_L, e.er, e.sc);
    end
  endtask
  initial begin
    int n;
    add(0, 0, S_I, 0, 0, 0, 0, 0, 1);
    add(0, 0, S_I, 0, 0, 0, 0, 0, 1);
    add(0, 0, S_I, 0);
    // 3 s nap: a tick every 4 cycles, done with the final tick, then ack
    add(LD, 24'h000003, S_A, 24'h000003);
    add(ST, 0, S_R, 24'h000003);
    for (int r = 2; r >= 0; r--) begin
      for (int k = 0; k < 3; k++) add(0, 0, S_R, 24'(r + 1));
      add(0, 0, r == 0 ? S_L : S_R, 24'(r), 1, r == 0);
    end
    add(0, 0, S_L, 0);
    add(AK, 0, S_I, 0);
    // invalid reload while armed, hour borrow, load ignored in RUN
    add(LD, 24'h010000, S_A, 24'h010000);
    add(LD, 24'h235960, S_A, 24'h010000, 0, 0, 1);
    add(ST, 0, S_R, 24'h010000, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(0, 0, S_R, 24'h010000, 0, 0, 1);
    add(0, 0, S_R, 24'h005959, 1, 0, 1);
    add(LD, 24'h000005, S_R, 24'h005959, 0, 0, 1);
    add(CA, 0, S_I, 0, 0, 0, 1);
    add(LD, 24'h250000, S_I, 0, 0, 0, 1);
    add(LD | ST, 24'h000010, S_I, 0, 0, 0, 1);
    // zero-length nap goes straight to ALARM without a tick
    add(LD, 24'h000000, S_A, 0);
    add(ST, 0, S_L, 0, 0, 1);
    add(0, 0, S_L, 0);
    add(CA | AK, 0, S_I, 0);
    // pause holds the prescaler mid-count
    add(LD, 24'h000002, S_A, 24'h000002);
    add(ST, 0, S_R, 24'h000002);
    add(0, 0, S_R, 24'h000002);
    add(0, 0, S_R, 24'h000002);
    add(PA, 0, S_P, 24'h000002);
    for (int k = 0; k < 20; k++) add(0, 0, S_P, 24'h000002);
    add(ST, 0, S_R, 24'h000002);
    add(0, 0, S_R, 24'h000002);
    add(0, 0, S_R, 24'h000001, 1);
    add(CA, 0, S_I, 0);
    // alarm then snooze handling
    add(LD, 24'h000001, S_A, 24'h000001);
    add(ST, 0, S_R, 24'h000001);
    for (int k = 0; k < 3; k++) add(0, 0, S_R, 24'h000001);
    add(0, 0, S_L, 0, 1, 1);
`ifdef NAP_SNOOZE_EN
    for (int s = 1; s <= 2; s++) begin
      add(SN, 0, S_R, 24'h000100, 0, 0, 0, 4'(s));
      for (int i = 1; i <= 240; i++)
        add(0, 0, i == 240 ? S_L : S_R, to_bcd(60 - i / 4), i % 4 == 0, i == 240, 0, 4'(s));
    end
    add(SN, 0, S_L, 0, 0, 0, 0, 2);
    add(AK, 0, S_I, 0, 0, 0, 0, 2);
    add(CA, 0, S_I, 0);
`else
    add(SN, 0, S_L, 0);
    add(AK, 0, S_I, 0);
`endif
    // reset mid-countdown clears everything including error
    add(LD, 24'h000005, S_A, 24'h000005);
    add(LD, 24'h00000A, S_A, 24'h000005, 0, 0, 1);
    add(ST, 0, S_R, 24'h000005, 0, 0, 1);
    add(0, 0, S_R, 24'h000005, 0, 0, 1);
    add(0, 0, S_I, 0, 0, 0, 0, 0, 1);
    add(0, 0, S_I, 0);
    n = 0;
    while (vecs.size() > 0) begin
      vec_t v, e;
      v = vecs.pop_front();
      reset = ~v.rs;
      {load, start, pause, cancel, ack, snooze} = v.in;
      set_time = v.t;
      sb.push_back(v);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk(e, n);
      n++;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
